// File: rtl/plru_way_alloc_pkg.sv
// Shared constants and tree-path helpers for the PLRU way allocator.
// Nodes are heap-ordered: level l starts at node 2^l-1, offset by the top l index bits.
package plru_way_alloc_pkg;

  localparam int STATS_CNT_W = 32;

  function automatic int plru_path_node(input int idx, input int lvl, input int idx_w);
    return ((1 << lvl) - 1) + (idx >> (idx_w - lvl));
  endfunction

  function automatic logic plru_path_bit(input int idx, input int lvl, input int idx_w);
    return 1'((idx >> (idx_w - 1 - lvl)) & 1);
  endfunction

endpackage

// File: rtl/plru_alloc_tree.sv
// Binary PLRU tree: touch points every node on the path away from the index; victim is combinational.
// Touch lands on the next edge; clear/reset zero the tree (victim then index 0).
module plru_alloc_tree
  import plru_way_alloc_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim_idx
);

  localparam int NODES = ENTRIES - 1;

  logic [NODES-1:0] tree;
  logic [NODES-1:0] tree_nxt;

  always_comb begin
    tree_nxt = tree;
    for (int l = 0; l < IDX_W; l++) begin
      tree_nxt[IDX_W'(plru_path_node(int'(touch_idx), l, IDX_W))] =
        ~plru_path_bit(int'(touch_idx), l, IDX_W);
    end
  end

  // Walk from the root; each node value picks the half holding the victim.
  always_comb begin
    logic [IDX_W-1:0] v;
    v = '0;
    for (int l = 0; l < IDX_W; l++) begin
      v[IDX_W-1-l] = tree[IDX_W'(plru_path_node(int'(v), l, IDX_W))];
    end
    victim_idx = v;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tree <= '0;
    end else if (touch_valid) begin
      tree <= tree_nxt;
    end
  end

endmodule

// File: rtl/plru_way_alloc.sv
// Fully-associative tag store with PLRU allocation; registered response one cycle after accept,
// stalls requests while a response is unconsumed. PLRU_WAY_ALLOC_STATS_EN adds hit/miss counters.
module plru_way_alloc
  import plru_way_alloc_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 20,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [IDX_W-1:0] rsp_idx_o,
  output logic             rsp_evict_o,
  output logic [TAG_W-1:0] rsp_evict_tag_o
`ifdef PLRU_WAY_ALLOC_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] hit_cnt_o,
  output logic [STATS_CNT_W-1:0] miss_cnt_o
`endif
);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             evict;
    logic [TAG_W-1:0] evict_tag;
  } rsp_t;

  logic [TAG_W-1:0] tags [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic             hit, free, evict, accept;
  logic [IDX_W-1:0] hit_idx, free_idx, victim_idx, alloc_idx;
  rsp_t             rsp;
  logic             rsp_valid;

  assign req_ready_o = ~flush_i & (~rsp_valid | rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == req_tag_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign evict     = ~hit & ~free;
  assign alloc_idx = hit ? hit_idx : (free ? free_idx : victim_idx);

  plru_alloc_tree #(.ENTRIES(ENTRIES)) u_tree (
    .clk         (clk_i),
    .rst         (rst_i),
    .clear       (flush_i),
    .touch_valid (accept),
    .touch_idx   (alloc_idx),
    .victim_idx  (victim_idx)
  );

  always_ff @(posedge clk_i) begin
    if (accept && !hit) begin
      tags[alloc_idx] <= req_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid <= '0;
    end else if (accept && !hit) begin
      valid[alloc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else if (accept) begin
      rsp_valid     <= 1'b1;
      rsp.hit       <= hit;
      rsp.idx       <= alloc_idx;
      rsp.evict     <= evict;
      rsp.evict_tag <= evict ? tags[alloc_idx] : '0;
    end else if (rsp_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o     = rsp_valid;
  assign rsp_hit_o       = rsp.hit;
  assign rsp_idx_o       = rsp.idx;
  assign rsp_evict_o     = rsp.evict;
  assign rsp_evict_tag_o = rsp.evict_tag;

`ifdef PLRU_WAY_ALLOC_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept) begin
      if (hit && !(&hit_cnt_o)) begin
        hit_cnt_o <= hit_cnt_o + 1'b1;
      end
      if (!hit && !(&miss_cnt_o)) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
